// File: rtl/acc_feeder.sv
// acc_feeder: streams one float32 vector into the CORDIC term/accumulate slave over
// Avalon-MM, then reads the accumulated sum back and returns it with the sample count.
module acc_feeder #(
    parameter int SAMPLE_SPACING = 2,
    parameter int DRAIN_CYCLES   = 24,
    parameter int READ_LATENCY   = 23,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             m_write,
    output logic             m_read,
    output logic             m_address,
    output logic [31:0]      m_writedata,
    input  logic [31:0]      m_readdata,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int SP_MAX  = (SAMPLE_SPACING > 1) ? SAMPLE_SPACING - 1 : 0;
    localparam int SP_W    = (SP_MAX > 0) ? $clog2(SP_MAX + 1) : 1;
    localparam int RL_LOAD = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
    localparam int TMR_MAX = (DRAIN_CYCLES > RL_LOAD) ? DRAIN_CYCLES : RL_LOAD;
    localparam int TMR_W   = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;

    localparam logic [SP_W-1:0]  SP_RELOAD  = SP_W'(SP_MAX);
    localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_CYCLES);
    localparam logic [TMR_W-1:0] RDLAT_LOAD = TMR_W'(RL_LOAD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FEED,
        S_DRAIN,
        S_READ,
        S_WAIT_RD,
        S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              m_write_q, m_write_d;
    logic              m_read_q, m_read_d;
    logic              m_address_q, m_address_d;
    logic [31:0]       m_writedata_q, m_writedata_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign in_ready = (state_q == S_FEED) && (sp_q == '0);
    assign accept   = in_ready && in_valid;

    // State register plus every registered output and counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            sp_q          <= '0;
            tmr_q         <= '0;
            m_write_q     <= 1'b0;
            m_read_q      <= 1'b0;
            m_address_q   <= 1'b0;
            m_writedata_q <= '0;
            out_data_q    <= '0;
            out_count_q   <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sp_q          <= sp_d;
            tmr_q         <= tmr_d;
            m_write_q     <= m_write_d;
            m_read_q      <= m_read_d;
            m_address_q   <= m_address_d;
            m_writedata_q <= m_writedata_d;
            out_data_q    <= out_data_d;
            out_count_q   <= out_count_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (in_valid) state_d = S_ARM;
            S_ARM:     state_d = S_FEED;
            S_FEED:    if (accept && in_last) state_d = S_DRAIN;
            S_DRAIN:   if (tmr_q == '0) state_d = S_READ;
            S_READ:    state_d = S_WAIT_RD;
            S_WAIT_RD: if (tmr_q == '0) state_d = S_OUT;
            S_OUT:     if (out_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Strobes are computed one cycle early so they appear registered in the target state
    always_comb begin
        m_write_d     = 1'b0;
        m_read_d      = 1'b0;
        m_address_d   = 1'b0;
        m_writedata_d = '0;
        out_data_d    = out_data_q;
        out_count_d   = out_count_q;
        out_valid_d   = out_valid_q;
        sp_d          = '0;
        tmr_d         = tmr_q;
        busy_d        = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    m_write_d   = 1'b1;
                    m_address_d = 1'b1;
                    out_count_d = '0;
                end
            end
            S_FEED: begin
                sp_d = (sp_q != '0) ? sp_q - SP_W'(1) : '0;
                if (accept) begin
                    m_write_d     = 1'b1;
                    m_writedata_d = in_data;
                    sp_d          = SP_RELOAD;
                    out_count_d   = sat_inc(out_count_q);
                    if (in_last) tmr_d = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else begin
                    m_read_d    = 1'b1;
                    m_address_d = 1'b1;
                end
            end
            S_READ: begin
                tmr_d = RDLAT_LOAD;
            end
            S_WAIT_RD: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else begin
                    out_data_d  = m_readdata;
                    out_valid_d = 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    assign m_write     = m_write_q;
    assign m_read      = m_read_q;
    assign m_address   = m_address_q;
    assign m_writedata = m_writedata_q;
    assign out_data    = out_data_q;
    assign out_count   = out_count_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_acc_feeder.sv
// tb_acc_feeder: directed bench for acc_feeder with an XOR-accumulating slave model
// whose read data appears exactly READ_LATENCY cycles after m_read.
`timescale 1ns/1ps
module tb_acc_feeder;

    localparam int SP = 2;
    localparam int DC = 24;
    localparam int RL = 23;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          m_write;
    logic          m_read;
    logic          m_address;
    logic [31:0]   m_writedata;
    logic [31:0]   m_readdata;
    logic [31:0]   out_data;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;

    acc_feeder #(
        .SAMPLE_SPACING(SP),
        .DRAIN_CYCLES  (DC),
        .READ_LATENCY  (RL),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .m_write    (m_write),
        .m_read     (m_read),
        .m_address  (m_address),
        .m_writedata(m_writedata),
        .m_readdata (m_readdata),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: address 1 write clears the sum, address 0 write folds the sample in by XOR
    logic [31:0] sl_acc = '0;
    logic [RL:1] rd_sh = '0;
    always @(posedge clk) begin
        if (m_write) sl_acc <= m_address ? 32'h0 : (sl_acc ^ m_writedata);
        rd_sh <= {rd_sh[RL-1:1], m_read};
    end
    assign m_readdata = rd_sh[RL] ? sl_acc : 32'h0;

    int          wr_cyc[$];
    logic        wr_adr[$];
    logic [31:0] wr_dat[$];
    int          rd_cyc[$];
    int          n_both = 0;
    int          n_idle_bad = 0;
    bit          ir_hist [0:8191];

    always @(negedge clk) begin
        if (m_write) begin
            wr_cyc.push_back(cyc);
            wr_adr.push_back(m_address);
            wr_dat.push_back(m_writedata);
        end
        if (m_read) rd_cyc.push_back(cyc);
        if (m_write && m_read) n_both <= n_both + 1;
        if (!m_write && !m_read && (m_address || m_writedata != 32'h0)) n_idle_bad <= n_idle_bad + 1;
        if (cyc < 8192) ir_hist[cyc] <= in_ready;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_cyc.delete();
        wr_adr.delete();
        wr_dat.delete();
        rd_cyc.delete();
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_in_ready"},    in_ready,    0);
        chk({pfx, "_m_write"},     m_write,     0);
        chk({pfx, "_m_read"},      m_read,      0);
        chk({pfx, "_m_address"},   m_address,   0);
        chk({pfx, "_m_writedata"}, m_writedata, 0);
        chk({pfx, "_out_data"},    out_data,    0);
        chk({pfx, "_out_count"},   out_count,   0);
        chk({pfx, "_out_valid"},   out_valid,   0);
        chk({pfx, "_busy"},        busy,        0);
    endtask

    // Drives n samples starting in the current cycle; optional idle gap after sample gap_after
    task automatic send_vec(input logic [31:0] d [4], input int n, input int gap_after,
                            input int gap_len, output int t0);
        t0 = cyc;
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            bit took = 1'b0;
            in_valid = 1'b1;
            in_data  = d[i];
            in_last  = (i == n - 1);
            while (!took && guard < 200) begin
                @(negedge clk);
                took = in_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (!took) begin
                chk("accept_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            if (i == gap_after) begin
                in_valid = 1'b0;
                repeat (gap_len) begin
                    @(posedge clk); #1;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_out(output int ovc, output logic [31:0] od, output logic [CW-1:0] oc);
        int guard = 0;
        ovc = -1;
        od  = '0;
        oc  = '0;
        while (guard < 300) begin
            @(negedge clk);
            if (out_valid) begin
                ovc = cyc;
                od  = out_data;
                oc  = out_count;
                break;
            end
            @(posedge clk); #1;
            guard++;
        end
        if (ovc < 0) chk("out_valid_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0]   d1 [4];
        logic [31:0]   d4 [4];
        logic [31:0]   od;
        logic [CW-1:0] oc;
        int            t0;
        int            ovc;
        int            h;
        int            bad_data;
        int            bad_cnt;
        int            bad_vld;
        int            bad_rdy;
        logic [7:0]    ir_bits;

        d4[0] = 32'h3F800000;
        d4[1] = 32'h40000000;
        d4[2] = 32'h40400000;
        d4[3] = 32'h40800000;

        // Reset, then ten quiet cycles
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        clear_log();
        repeat (10) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk_quiet("rst");
        chk("rst_no_writes", wr_cyc.size(), 0);
        chk("rst_no_reads",  rd_cyc.size(), 0);
        @(posedge clk); #1;

        // One-sample job, timing end to end
        out_ready = 1'b1;
        clear_log();
        d1[0] = 32'h3F800000; d1[1] = '0; d1[2] = '0; d1[3] = '0;
        send_vec(d1, 1, -1, 0, t0);
        wait_out(ovc, od, oc);
        chk("j1_nwrites", wr_cyc.size(), 2);
        if (wr_cyc.size() >= 2) begin
            chk("j1_arm_cyc",  wr_cyc[0], t0 + 1);
            chk("j1_arm_addr", wr_adr[0], 1);
            chk("j1_arm_data", wr_dat[0], 0);
            chk("j1_wr_cyc",   wr_cyc[1], t0 + 3);
            chk("j1_wr_addr",  wr_adr[1], 0);
            chk("j1_wr_data",  wr_dat[1], 32'h3F800000);
        end
        chk("j1_nreads", rd_cyc.size(), 1);
        if (rd_cyc.size() >= 1) chk("j1_rd_cyc", rd_cyc[0], t0 + 28);
        chk("j1_ov_cyc", ovc, t0 + 52);
        chk("j1_data",   od,  32'h3F800000);
        chk("j1_count",  oc,  1);
        @(negedge clk);
        chk("j1_idle_busy", busy, 0);
        @(posedge clk); #1;

        // Four samples, in_valid held high
        clear_log();
        send_vec(d4, 4, -1, 0, t0);
        wait_out(ovc, od, oc);
        chk("j4_nwrites", wr_cyc.size(), 5);
        if (wr_cyc.size() >= 5) begin
            for (int k = 1; k <= 4; k++) begin
                chk($sformatf("j4_wr%0d_cyc", k),  wr_cyc[k], t0 + 1 + 2 * k);
                chk($sformatf("j4_wr%0d_data", k), wr_dat[k], d4[k-1]);
            end
        end
        for (int k = 0; k < 8; k++) ir_bits[k] = ir_hist[t0 + 2 + k];
        chk("j4_in_ready_pattern", ir_bits, 8'h55);
        if (rd_cyc.size() >= 1) chk("j4_rd_cyc", rd_cyc[0], t0 + 34);
        chk("j4_ov_cyc", ovc, t0 + 58);
        chk("j4_data",   od,  32'h7F400000);
        chk("j4_count",  oc,  4);

        // Same vector with a five-cycle source gap after the second sample
        clear_log();
        send_vec(d4, 4, 1, 5, t0);
        wait_out(ovc, od, oc);
        chk("gap_nwrites", wr_cyc.size(), 5);
        if (wr_cyc.size() >= 5) begin
            chk("gap_wr3_cyc",  wr_cyc[3], t0 + 11);
            chk("gap_wr4_cyc",  wr_cyc[4], t0 + 13);
            chk("gap_wr4_data", wr_dat[4], 32'h40800000);
        end
        chk("gap_ov_cyc", ovc, t0 + 62);
        chk("gap_data",   od,  32'h7F400000);
        chk("gap_count",  oc,  4);

        // Back-pressured result while the next vector waits at the input
        out_ready = 1'b0;
        d1[0] = 32'h40490FDB;
        send_vec(d1, 1, -1, 0, t0);
        wait_out(ovc, od, oc);
        chk("bp_data",  od, 32'h40490FDB);
        chk("bp_count", oc, 1);
        in_valid = 1'b1;
        in_data  = 32'h40000000;
        in_last  = 1'b1;
        clear_log();
        bad_data = 0; bad_cnt = 0; bad_vld = 0; bad_rdy = 0;
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            if (out_data !== od)  bad_data++;
            if (out_count !== oc) bad_cnt++;
            if (out_valid !== 1'b1) bad_vld++;
            if (in_ready !== 1'b0) bad_rdy++;
            @(posedge clk); #1;
        end
        chk("bp_data_stable",  bad_data, 0);
        chk("bp_count_stable", bad_cnt,  0);
        chk("bp_valid_held",   bad_vld,  0);
        chk("bp_in_ready_low", bad_rdy,  0);
        chk("bp_no_writes",    wr_cyc.size(), 0);
        out_ready = 1'b1;
        h = cyc;
        @(negedge clk);
        chk("bp_valid_at_hs", out_valid, 1);
        @(posedge clk); #1;
        d1[0] = 32'h40000000;
        send_vec(d1, 1, -1, 0, t0);
        wait_out(ovc, od, oc);
        if (wr_cyc.size() >= 1) begin
            chk("bp_next_arm_cyc",  wr_cyc[0], h + 2);
            chk("bp_next_arm_addr", wr_adr[0], 1);
        end else begin
            chk("bp_next_nwrites", wr_cyc.size(), 2);
        end
        chk("bp_next_data",  od, 32'h40000000);
        chk("bp_next_count", oc, 1);

        // Reset during DRAIN aborts the job
        clear_log();
        d1[0] = 32'h11111111; d1[1] = 32'h22222222;
        send_vec(d1, 2, -1, 0, t0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_quiet("abort");
        repeat (30) begin
            @(posedge clk); #1;
        end
        chk("abort_no_read", rd_cyc.size(), 0);
        clear_log();
        d1[0] = 32'h3F800000;
        send_vec(d1, 1, -1, 0, t0);
        wait_out(ovc, od, oc);
        if (wr_cyc.size() >= 1) begin
            chk("post_arm_cyc",  wr_cyc[0], t0 + 1);
            chk("post_arm_addr", wr_adr[0], 1);
        end else begin
            chk("post_nwrites", wr_cyc.size(), 2);
        end
        chk("post_data",  od,  32'h3F800000);
        chk("post_count", oc,  1);
        chk("post_ov_cyc", ovc, t0 + 52);

        chk("strobe_overlap", n_both, 0);
        chk("idle_addr_data", n_idle_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/acc_feeder.md
# acc_feeder

Stream-to-Avalon master that drives the CORDIC term/accumulate slave on the clock domain it shares. It accepts one float32 sample vector per job on a valid/ready stream, delimited by `in_last`. It arms the slave's new-sum mode, then writes each sample at a fixed spacing. After the pipelines drain it reads back the accumulated sum and presents it on a valid/ready result port together with the sample count.

## Interface
- `SAMPLE_SPACING`, 2: minimum cycles between starts of consecutive sample writes (≥1).
- `DRAIN_CYCLES`, 24: idle cycles after the final sample write before the read is issued.
- `READ_LATENCY`, 23: cycles from `m_read` assertion to valid `m_readdata`.
- `CNT_W`, 16: width of the sample counter.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_data` in 32: float32 sample.
- `in_valid` in 1: sample present.
- `in_last` in 1: sample is the last of the vector.
- `in_ready` out 1: sample accepted when `in_valid && in_ready`.
- `m_write` out 1: Avalon write strobe to the slave.
- `m_read` out 1: Avalon read strobe to the slave.
- `m_address` out 1: 0 = sample register, 1 = result/arm register.
- `m_writedata` out 32: write data.
- `m_readdata` in 32: slave read data. Valid only in the cycle `READ_LATENCY` after `m_read`; zero otherwise.
- `out_data` out 32: accumulated float32 sum.
- `out_count` out CNT_W: number of samples in the vector.
- `out_valid` out 1: result present.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.
- `busy` out 1: high in every state except IDLE.

## Operation
- All outputs are registered except `in_ready`, which is decoded from state and the spacing counter.
- **IDLE**: `in_ready`=0. When `in_valid`=1, go to ARM. The sample is not consumed.
- **ARM** (1 cycle): `m_write`=1, `m_address`=1, `m_writedata`=0. This clears the slave's result and starts a new sum. Clear `out_count`. Go to FEED.
- **FEED**:
  - `in_ready`=1 iff the spacing counter is 0.
  - On accept: register `in_data` onto `m_writedata` with `m_address`=0 and `m_write`=1 for exactly the next cycle. Load the spacing counter with `SAMPLE_SPACING-1`. Increment `out_count`, saturating at 2^CNT_W−1.
  - If the accepted beat has `in_last`=1, go to DRAIN after issuing its write.
- **DRAIN**: count `DRAIN_CYCLES` cycles with no strobes, then go to READ.
- **READ** (1 cycle): `m_read`=1, `m_address`=1. Go to WAIT_RD.
- **WAIT_RD**: count `READ_LATENCY` cycles from the `m_read` cycle. In that cycle capture `m_readdata` into `out_data`, then go to OUT.
- **OUT**: `out_valid`=1 and `out_data`/`out_count` are held stable until `out_ready`=1. On handshake, drop `out_valid` and go to IDLE.
- `m_write` and `m_read` are never high in the same cycle. `m_address` and `m_writedata` return to 0 when no strobe is active.
- Stream data is ignored whenever `in_ready`=0. An `in_last` during DRAIN, READ, WAIT_RD or OUT belongs to the next job.

## Timing
- Reset values: `in_ready`=0, `m_write`=0, `m_read`=0, `m_address`=0, `m_writedata`=0, `out_data`=0, `out_count`=0, `out_valid`=0, `busy`=0, state IDLE, all counters 0.
- A reset mid-job aborts immediately to IDLE with the values above. Partial accumulation in the slave is abandoned; the next job's ARM clears it.
- Job start: `in_valid` rises in cycle t (IDLE) → ARM write in t+1 → `in_ready`=1 in t+2.
- Sample spacing: accept in cycle a → write in a+1 → next accept no earlier than a+SAMPLE_SPACING. With `SAMPLE_SPACING`=1, accepts are back-to-back and writes occur every cycle.
- Final write in cycle w → `m_read` in w+1+DRAIN_CYCLES = r → capture in r+READ_LATENCY → `out_valid` in r+READ_LATENCY+1.
- With defaults, a 1-sample job that starts at t has `out_valid` at t+52.
- `out_ready` already high when `out_valid` rises: handshake in that cycle; IDLE next cycle; a new job may start (ARM) the cycle after.
- `in_valid` dropping mid-vector: FEED waits indefinitely; the spacing counter still decrements.

## Test plan
- Reset then `in_valid`=0 for 10 cycles → all outputs 0, no strobes, `busy`=0.
- 1-sample vector, 0x3F800000 with `in_last`, into a slave model that echoes the last sample → ARM write (addr 1, data 0) at t+1, sample write at t+3, `m_read` at t+28, `out_valid` at t+52 with `out_data`=0x3F800000 and `out_count`=1.
- 4-sample vector with `in_valid` held high, `SAMPLE_SPACING`=2 → writes at cycles t+3, t+5, t+7, t+9; `in_ready` toggles 1,0; `out_count`=4.
- Gappy source: `in_valid` low for 5 cycles between samples 2 and 3 → FEED stalls, no extra writes, and the same final result and count as the gap-free run.
- `out_ready` held low 20 cycles after `out_valid` → `out_data` and `out_count` stable, `in_ready`=0 throughout; a new vector starts only after the handshake.
- Reset asserted during DRAIN → next cycle IDLE with all outputs 0; a following job starts with an ARM write and a count restarting at 1.
